mul_out_rescale: RTL and testbench
==================================

MUL_OUT_RESCALE -- requirements
Module: mul_out_rescale

Interface
REQ-001 SHALL have parameter DW, default 32, meaning lane width (IEEE fp32, 8-bit exponent).
REQ-002 SHALL have parameter DEPTH, default 64, meaning buffer lines per batch (power of two).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  4*DW  four fp32 lanes from mul_tree_top interface_out.
REQ-006 SHALL have port in_vld  input  1  in_data valid (mul_tree_top output_vld).
REQ-007 SHALL have port in_ready  output  1  line accepted when in_vld && in_ready.
REQ-008 SHALL have port max_exponent  input  8  batch maximum biased exponent.
REQ-009 SHALL have port max_exponent_vld  input  1  max_exponent valid.
REQ-010 SHALL have port max_exponent_ready  output  1  exponent accepted when vld && ready; drives mul_tree_top max_exponent_ready.
REQ-011 SHALL have port out_data  output  4*DW  rescaled lanes.
REQ-012 SHALL have port out_vld  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_last  output  1  final line of batch, qualified by out_vld.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE, FILL, DRAIN; count register 0..DEPTH holds lines buffered.
REQ-017 IDLE: in_ready=1, max_exponent_ready=0; first accepted line -> write addr 0, count=1, go FILL.
REQ-018 FILL: in_ready=(count<DEPTH); each accept writes at addr count, count+1; full -> in_ready=0, line held upstream.
REQ-019 FILL: max_exponent_ready=1; on exponent handshake latch max_exponent, go DRAIN; a line accepted in the same cycle SHALL be part of the batch.
REQ-020 DRAIN: in_ready=0, max_exponent_ready=0; lines read in write order from addr 0.
REQ-021 Output stage SHALL be registered: first out_vld exactly 1 cycle after entering DRAIN; out_data/out_vld held stable while out_vld && !out_ready.
REQ-022 Back-to-back: with out_ready held high, one line per cycle, no bubbles.
REQ-023 out_last=1 on line index count-1; after its handshake: count=0, out_vld=0, go IDLE next cycle.
REQ-024 Per lane, e=exponent field, M=latched max: e==0 -> lane unchanged (zero/denormal kept as signed zero, mantissa cleared); e==255 -> unchanged (Inf/NaN).
REQ-025 Otherwise new_e = e - M + 127 computed in 10-bit signed; new_e<=0 -> signed zero; new_e>=255 -> e=254, mantissa all-ones (saturate); else exponent replaced, sign and mantissa kept.
REQ-026 Rescale SHALL be combinational between buffer read and output register; no extra latency.
REQ-027 in_vld while in DRAIN SHALL be ignored (in_ready=0); exponent vld in IDLE SHALL be ignored.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, count=0, latched M=0, out_vld=0, out_last=0, out_data=0, busy=0; in_ready=1 after release.
REQ-029 Reset mid-batch SHALL discard buffered lines; buffer memory contents need not be cleared.

Structure
REQ-030 FSM state enum, DW, fp32 field widths and bias 127 SHALL live in shared package mul_pkg alongside defines.vh values.
REQ-031 Buffer SHALL be a sub-module simple_dp_ram (1 write, 1 read port, synchronous read, DEPTH x 4*DW), inferable as BRAM.

Verification
REQ-032 4 lines, each lane 0x3F800000, M=0x81 -> 4 outputs, each lane 0x3E800000, out_last on 4th.
REQ-033 Lane 0x00000000, 0x7F800000, 0x80000001 with M=0x90 -> 0x00000000, 0x7F800000, 0x80000000 unchanged/flushed.
REQ-034 Lane 0x01000000 (e=2), M=0xFE -> signed zero; lane e=0xFE, M=0x01 -> 0x7F7FFFFF saturated.
REQ-035 DEPTH lines then in_vld held: in_ready=0 at count=DEPTH; exponent sent -> DRAIN of 64 lines, order preserved.
REQ-036 out_ready toggled 1/0 randomly during DRAIN -> no loss, no duplication, data stable while stalled.
REQ-037 rst asserted after 10 lines mid-FILL -> outputs at reset values immediately; next batch of 3 lines drains 3 lines only.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and fp32 field constants for the multiplier-tree output path.
// Holds the rescale FSM states and the per-lane exponent rescale rule.
package mul_pkg;

  localparam int FP_DW    = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;
  localparam int LANES    = 4;

  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
  localparam logic [FP_EXP_W-1:0] FP_EXP_SAT = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } rescale_state_t;

  // Shift one fp32 lane so the batch maximum exponent lands on the bias.
  function automatic logic [FP_DW-1:0] rescale_lane(input logic [FP_DW-1:0] x,
                                                    input logic [FP_EXP_W-1:0] m);
    logic                  sign;
    logic [FP_EXP_W-1:0]   e;
    logic signed [9:0]     new_e;
    logic [FP_DW-1:0]      r;
    sign  = x[FP_DW-1];
    e     = x[FP_DW-2 -: FP_EXP_W];
    new_e = $signed({2'b00, e}) - $signed({2'b00, m}) + $signed(10'(FP_BIAS));
    r     = x;
    if (e == '0) begin
      r = {sign, {(FP_DW-1){1'b0}}};
    end else if (e == FP_EXP_MAX) begin
      r = x;
    end else if (new_e <= 10'sd0) begin
      r = {sign, {(FP_DW-1){1'b0}}};
    end else if (new_e >= 10'sd255) begin
      r = {sign, FP_EXP_SAT, {FP_MAN_W{1'b1}}};
    end else begin
      r = {sign, new_e[FP_EXP_W-1:0], x[FP_MAN_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/simple_dp_ram.sv
// Simple dual-port buffer: one write port, one registered read port with enable.
// No reset on the array or read register so it maps onto block RAM.
module simple_dp_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mul_out_rescale.sv
// Buffers one batch of multiplier-tree lines, waits for the batch maximum
// exponent, then replays the lines with every lane rescaled against it.
module mul_out_rescale
  import mul_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4*DW-1:0] in_data,
  input  logic            in_vld,
  output logic            in_ready,
  input  logic [7:0]      max_exponent,
  input  logic            max_exponent_vld,
  output logic            max_exponent_ready,
  output logic [4*DW-1:0] out_data,
  output logic            out_vld,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rescale_state_t  state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   a_idx_reg;
  logic            a_vld_reg;
  logic [7:0]      max_e_reg;
  logic [4*DW-1:0] out_data_reg;
  logic            out_vld_reg;
  logic            out_last_reg;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            rd_en;
  logic            exp_fire;
  logic            b_load;
  logic            finish;
  logic [4*DW-1:0] rd_data;
  logic [4*DW-1:0] rescaled;

  simple_dp_ram #(
    .WIDTH (4*DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (rd_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign rescaled[gi*DW +: DW] = rescale_lane(rd_data[gi*DW +: DW], max_e_reg);
    end
  endgenerate

  // Two-stage drain pipeline: RAM read register, then the output register.
  assign b_load = a_vld_reg && (!out_vld_reg || out_ready);
  assign finish = (state_reg == ST_DRAIN) && out_vld_reg && out_ready && out_last_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    in_ready           = 1'b0;
    max_exponent_ready = 1'b0;
    wr_en              = 1'b0;
    wr_addr            = count_reg[AW-1:0];
    exp_fire           = 1'b0;
    rd_en              = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        wr_addr  = '0;
        if (in_vld) begin
          wr_en      = 1'b1;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready           = (count_reg < CW'(DEPTH));
        max_exponent_ready = 1'b1;
        wr_en              = in_vld && in_ready;
        exp_fire           = max_exponent_vld;
        // Prefetch line 0 on the exponent handshake so output appears one cycle into DRAIN.
        rd_en              = max_exponent_vld && !a_vld_reg;
        if (max_exponent_vld) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rd_en = (rd_ptr_reg < count_reg) && (!a_vld_reg || b_load);
        if (finish) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      a_idx_reg    <= '0;
      a_vld_reg    <= 1'b0;
      max_e_reg    <= '0;
      out_data_reg <= '0;
      out_vld_reg  <= 1'b0;
      out_last_reg <= 1'b0;
    end else begin
      if (exp_fire) begin
        max_e_reg <= max_exponent;
      end
      if (finish) begin
        count_reg    <= '0;
        rd_ptr_reg   <= '0;
        a_vld_reg    <= 1'b0;
        out_vld_reg  <= 1'b0;
        out_last_reg <= 1'b0;
      end else begin
        if (wr_en) begin
          count_reg <= count_reg + CW'(1);
        end
        if (rd_en) begin
          rd_ptr_reg <= rd_ptr_reg + CW'(1);
          a_idx_reg  <= rd_ptr_reg;
          a_vld_reg  <= 1'b1;
        end else if (b_load) begin
          a_vld_reg <= 1'b0;
        end
        if (b_load) begin
          out_vld_reg  <= 1'b1;
          out_data_reg <= rescaled;
          out_last_reg <= (a_idx_reg == count_reg - CW'(1));
        end else if (out_ready) begin
          out_vld_reg <= 1'b0;
        end
      end
    end
  end

  assign out_data = out_data_reg;
  assign out_vld  = out_vld_reg;
  assign out_last = out_last_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mul_out_rescale.sv
// Self-checking bench for mul_out_rescale: directed fp32 cases plus randomized
// batches compared against a plain-arithmetic lane model and an expected queue.
module tb_mul_out_rescale;

  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [4*DW-1:0] in_data;
  logic            in_vld;
  logic            in_ready;
  logic [7:0]      max_exponent;
  logic            max_exponent_vld;
  logic            max_exponent_ready;
  logic [4*DW-1:0] out_data;
  logic            out_vld;
  logic            out_ready;
  logic            out_last;
  logic            busy;

  mul_out_rescale #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_data            (in_data),
    .in_vld             (in_vld),
    .in_ready           (in_ready),
    .max_exponent       (max_exponent),
    .max_exponent_vld   (max_exponent_vld),
    .max_exponent_ready (max_exponent_ready),
    .out_data           (out_data),
    .out_vld            (out_vld),
    .out_ready          (out_ready),
    .out_last           (out_last),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            last;
    logic [4*DW-1:0] data;
  } exp_t;

  exp_t            exp_q[$];
  logic [4*DW-1:0] line_buf [DEPTH];
  bit              rnd_ready = 1'b0;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // fp32 rescale rule stated directly in integer arithmetic.
  function automatic logic [31:0] model_lane(input logic [31:0] x, input logic [7:0] m);
    int   e;
    int   ne;
    logic s;
    e  = int'(x[30:23]);
    s  = x[31];
    ne = e - int'(m) + 127;
    if (e == 0)   return {s, 31'd0};
    if (e == 255) return x;
    if (ne <= 0)  return {s, 31'd0};
    if (ne >= 255) return {s, 8'd254, 23'h7FFFFF};
    return {s, 8'(ne), x[22:0]};
  endfunction

  function automatic logic [127:0] model_line(input logic [127:0] l, input logic [7:0] m);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = model_lane(l[k*32 +: 32], m);
    return r;
  endfunction

  function automatic logic [31:0] rand_lane();
    int          k;
    logic [31:0] x;
    k = int'($urandom_range(0, 9));
    x = $urandom;
    if (k == 0) x[30:23] = 8'h00;
    else if (k == 1) x[30:23] = 8'hFF;
    return x;
  endfunction

  function automatic logic [127:0] rand_line();
    return {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
  endfunction

  // Downstream ready: random toggling when enabled, otherwise held high.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every output handshake against the queue, plus stall stability.
  logic            prev_vld = 1'b0;
  logic            prev_rdy = 1'b0;
  logic            prev_last = 1'b0;
  logic [4*DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        chk("stall_vld", 128'(out_vld), 128'(1'b1));
        chk("stall_data", out_data, prev_data);
        chk("stall_last", 128'(out_last), 128'(prev_last));
      end
      if (out_vld && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_out: got line %h, want no output (t=%0t)", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", 128'(out_last), 128'(e.last));
        end
      end
      prev_vld  = out_vld;
      prev_rdy  = out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic send_line(input logic [127:0] d);
    int n;
    @(negedge clk);
    in_vld  = 1'b1;
    in_data = d;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  // Exponent handshake; optionally carries the final line in the same cycle.
  task automatic send_exp(input logic [7:0] m, input bit combo, input logic [127:0] d,
                          input bit keep_in);
    int n;
    @(negedge clk);
    if (combo) begin
      in_vld  = 1'b1;
      in_data = d;
      chk("combo_in_ready", 128'(in_ready), 128'(1'b1));
    end else if (!keep_in) begin
      in_vld = 1'b0;
    end
    max_exponent     = m;
    max_exponent_vld = 1'b1;
    n = 0;
    while (!max_exponent_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("exp_ready_wait", 128'(max_exponent_ready), 128'(1'b1));
    @(posedge clk);
    @(negedge clk);
    max_exponent_vld = 1'b0;
    if (!keep_in) in_vld = 1'b0;
    chk("drain_lat0_vld", 128'(out_vld), 128'(1'b0));
    chk("drain_busy", 128'(busy), 128'(1'b1));
    @(negedge clk);
    chk("drain_lat1_vld", 128'(out_vld), 128'(1'b1));
  endtask

  task automatic run_batch(input int n, input logic [7:0] m, input bit rnd,
                           input bit use_model, input bit hold_extra);
    bit combo;
    int w;
    rnd_ready = rnd;
    if (use_model)
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), model_line(line_buf[i], m)});
    combo = !hold_extra && (n >= 2) && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < n - int'(combo); i++) begin
      send_line(line_buf[i]);
      if (rnd && $urandom_range(0, 3) == 0) idle_cycle();
    end
    if (hold_extra) begin
      @(negedge clk);
      in_vld  = 1'b1;
      in_data = rand_line();
      for (int k = 0; k < 3; k++) begin
        chk("full_in_ready", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
      end
    end
    send_exp(m, combo, line_buf[n-1], hold_extra);
    if (hold_extra) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("drain_in_ready", 128'(in_ready), 128'(1'b0));
      end
      in_vld = 1'b0;
    end
    w = 0;
    while (busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_done", 128'(busy), 128'(1'b0));
    chk("batch_leftover", 128'(exp_q.size()), 128'(0));
    chk("idle_in_ready", 128'(in_ready), 128'(1'b1));
    rnd_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    in_data          = '0;
    in_vld           = 1'b0;
    max_exponent     = '0;
    max_exponent_vld = 1'b0;
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_out_vld", 128'(out_vld), 128'(1'b0));
    chk("rst_out_last", 128'(out_last), 128'(1'b0));
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_exp_ready", 128'(max_exponent_ready), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    chk("model_one", 128'(model_lane(32'h3F800000, 8'h81)), 128'(32'h3E800000));
    chk("model_denorm", 128'(model_lane(32'h80000001, 8'h90)), 128'(32'h80000000));
    chk("model_inf", 128'(model_lane(32'h7F800000, 8'h90)), 128'(32'h7F800000));
    chk("model_flush", 128'(model_lane(32'h01000000, 8'hFE)), 128'(32'h00000000));
    chk("model_sat", 128'(model_lane(32'h7F000000, 8'h01)), 128'(32'h7F7FFFFF));

    // Exponent offered in IDLE must be ignored.
    @(negedge clk);
    max_exponent     = 8'h55;
    max_exponent_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_exp_ready", 128'(max_exponent_ready), 128'(1'b0));
      chk("idle_busy", 128'(busy), 128'(1'b0));
    end
    max_exponent_vld = 1'b0;

    // Four lines of 1.0 rescaled by 2^-2.
    for (int i = 0; i < 4; i++) begin
      line_buf[i] = {4{32'h3F800000}};
      exp_q.push_back({(i == 3), {4{32'h3E800000}}});
    end
    run_batch(4, 8'h81, 1'b0, 1'b0, 1'b0);

    // Zero, Inf, denormal and a normal lane.
    line_buf[0] = {32'h3F800000, 32'h80000001, 32'h7F800000, 32'h00000000};
    exp_q.push_back({1'b1, {32'h37000000, 32'h80000000, 32'h7F800000, 32'h00000000}});
    run_batch(1, 8'h90, 1'b0, 1'b0, 1'b0);

    // Underflow to signed zero.
    line_buf[0] = {32'h81000000, 32'h01234567, 32'h01000000, 32'h81000000};
    exp_q.push_back({1'b1, {32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000}});
    run_batch(1, 8'hFE, 1'b0, 1'b0, 1'b0);

    // Overflow saturation and ordinary upward shifts.
    line_buf[0] = {32'h40000000, 32'h3F800000, 32'hFF123456, 32'h7F000000};
    exp_q.push_back({1'b1, {32'h7F000000, 32'h7E800000, 32'hFF7FFFFF, 32'h7F7FFFFF}});
    run_batch(1, 8'h01, 1'b0, 1'b0, 1'b0);

    // Full buffer with in_vld held, randomly stalled drain.
    for (int i = 0; i < DEPTH; i++) line_buf[i] = rand_line();
    run_batch(DEPTH, 8'($urandom_range(1, 254)), 1'b1, 1'b1, 1'b1);

    // Random batch sizes and exponents under random backpressure.
    for (int b = 0; b < 6; b++) begin
      int n;
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) line_buf[i] = rand_line();
      run_batch(n, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
    end

    // Reset in the middle of filling discards the partial batch.
    for (int i = 0; i < 10; i++) send_line(rand_line());
    idle_cycle();
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    chk("midrst_out_vld", 128'(out_vld), 128'(1'b0));
    chk("midrst_out_last", 128'(out_last), 128'(1'b0));
    chk("midrst_out_data", out_data, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) line_buf[i] = rand_line();
    run_batch(3, 8'($urandom_range(1, 254)), 1'b1, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
